// File: rtl/ahb_async_sram_multibeat_if.sv
// rtl/ahb_async_sram_multibeat_if.sv - AHB-Lite bus bundle between the splitter and the SRAM slave
interface ahb_async_sram_multibeat_if #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32
);
    logic              ahbls_hready_resp;
    logic              ahbls_hready;
    logic              ahbls_hresp;
    logic [W_ADDR-1:0] ahbls_haddr;
    logic              ahbls_hwrite;
    logic [1:0]        ahbls_htrans;
    logic [2:0]        ahbls_hsize;
    logic [2:0]        ahbls_hburst;
    logic [3:0]        ahbls_hprot;
    logic              ahbls_hmastlock;
    logic [W_DATA-1:0] ahbls_hwdata;
    logic [W_DATA-1:0] ahbls_hrdata;

    modport master (
        input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
        output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
               ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata
    );

    modport slave (
        output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
        input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
               ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata
    );
endinterface

// File: rtl/ahb_async_sram_multibeat.sv
// rtl/ahb_async_sram_multibeat.sv - AHB-Lite slave splitting bus transfers into async SRAM beats
// Optional out-of-range ERROR response: define AHB_SRAM_ERR_EN.
module ahb_async_sram_multibeat #(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32,
    parameter int DEPTH       = 1 << 16,
    parameter int W_SRAM_DATA = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    ahb_async_sram_multibeat_if.slave  ahbls,
    output logic [W_SRAM_ADDR-1:0]     sram_addr,
    inout  wire  [W_SRAM_DATA-1:0]     sram_dq,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic [W_SRAM_DATA/8-1:0]   sram_byte_n
);
    localparam int LANE_BYTES = W_SRAM_DATA / 8;
    localparam int LANE_BITS  = $clog2(LANE_BYTES);
    localparam int RATIO      = W_DATA / W_SRAM_DATA;
    localparam int LW         = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RBEAT, S_WSETUP, S_WSTROBE, S_ERR1, S_ERR2} state_t;

    state_t                  state, n_state;
    logic [LW-1:0]           beat, n_beat;
    logic [3:0]              wcnt, n_wcnt;
    logic [W_SRAM_ADDR-1:0]  c_base, nc_base;
    logic [LW-1:0]           c_lane, nc_lane, c_last, cur_lane;
    logic [LANE_BYTES-1:0]   c_mask, nc_mask;
    logic [W_SRAM_DATA-1:0]  rbuf [RATIO];
    logic                    dq_oe;
    logic                    n_ce_n, n_we_n, n_oe_n, n_dq_oe;
    logic [LANE_BYTES-1:0]   n_byte_n;
    logic [W_SRAM_ADDR-1:0]  n_addr;
    logic                    accept, addr_err, load, beat_end, at_boundary;
    logic [W_SRAM_ADDR-1:0]  a_base;
    logic [LW-1:0]           a_lane;
    logic [W_SRAM_DATA-1:0]  wr_word;
    logic                    unused;

    function automatic logic [LW-1:0] last_of(input logic [2:0] size);
        int nb;
        nb = (1 << size) / LANE_BYTES;
        if (nb < 1) nb = 1;
        if (nb > RATIO) nb = RATIO;
        return LW'(nb - 1);
    endfunction

    // Byte lanes touched within one SRAM word; full-word beats enable every lane.
    function automatic logic [LANE_BYTES-1:0] mask_of(input logic [2:0] size, input logic [W_ADDR-1:0] addr);
        int nbytes, off;
        logic [LANE_BYTES-1:0] m;
        nbytes = 1 << size;
        off    = int'(addr & W_ADDR'(LANE_BYTES - 1));
        for (int i = 0; i < LANE_BYTES; i++)
            m[i] = (nbytes >= LANE_BYTES) || (i >= off && i < off + nbytes);
        return m;
    endfunction

    assign accept = ahbls.ahbls_hready && ahbls.ahbls_htrans[1];
    assign a_base = ahbls.ahbls_haddr[LANE_BITS +: W_SRAM_ADDR];
    assign unused = ^{ahbls.ahbls_hburst, ahbls.ahbls_hprot, ahbls.ahbls_hmastlock, ahbls.ahbls_haddr};

    generate
        if (RATIO > 1) begin : g_lane
            assign a_lane = ahbls.ahbls_haddr[LANE_BITS +: LW];
        end else begin : g_nolane
            assign a_lane = '0;
        end
    endgenerate

`ifdef AHB_SRAM_ERR_EN
    assign addr_err = ahbls.ahbls_haddr >= W_ADDR'(DEPTH * LANE_BYTES);
`else
    assign addr_err = 1'b0;
`endif

    assign cur_lane = c_lane + beat;
    assign wr_word  = ahbls.ahbls_hwdata[cur_lane * W_SRAM_DATA +: W_SRAM_DATA];
    assign sram_dq  = dq_oe ? wr_word : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            beat        <= '0;
            wcnt        <= '0;
            c_base      <= '0;
            c_lane      <= '0;
            c_last      <= '0;
            c_mask      <= '0;
            sram_addr   <= '0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_byte_n <= '1;
            dq_oe       <= 1'b0;
        end else begin
            state       <= n_state;
            beat        <= n_beat;
            wcnt        <= n_wcnt;
            if (load) begin
                c_base <= a_base;
                c_lane <= a_lane;
                c_last <= last_of(ahbls.ahbls_hsize);
                c_mask <= mask_of(ahbls.ahbls_hsize, ahbls.ahbls_haddr);
            end
            sram_addr   <= n_addr;
            sram_ce_n   <= n_ce_n;
            sram_we_n   <= n_we_n;
            sram_oe_n   <= n_oe_n;
            sram_byte_n <= n_byte_n;
            dq_oe       <= n_dq_oe;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RBEAT && beat_end)
            rbuf[cur_lane] <= sram_dq;
    end

    // A boundary cycle is the one where hready_resp is high and a new aphase may be taken.
    always_comb begin
        n_state     = state;
        n_beat      = beat;
        n_wcnt      = wcnt;
        load        = 1'b0;
        beat_end    = (wcnt == 4'(WAIT_CYCLES));
        at_boundary = (state == S_IDLE) || (state == S_ERR2) ||
                      (((state == S_RBEAT) || (state == S_WSTROBE)) && beat_end && (beat == c_last));
        case (state)
            S_RBEAT, S_WSTROBE: begin
                if (!beat_end) begin
                    n_wcnt = wcnt + 4'd1;
                end else if (beat != c_last) begin
                    n_beat  = beat + LW'(1);
                    n_wcnt  = '0;
                    n_state = (state == S_RBEAT) ? S_RBEAT : S_WSETUP;
                end
            end
            S_WSETUP: begin
                n_state = S_WSTROBE;
                n_wcnt  = '0;
            end
            S_ERR1:  n_state = S_ERR2;
            default: n_state = state;
        endcase
        if (at_boundary) begin
            if (accept) begin
                load    = 1'b1;
                n_beat  = '0;
                n_wcnt  = '0;
                n_state = addr_err ? S_ERR1 : (ahbls.ahbls_hwrite ? S_WSETUP : S_RBEAT);
            end else begin
                n_state = S_IDLE;
            end
        end
    end

    always_comb begin
        nc_base  = load ? a_base : c_base;
        nc_lane  = load ? a_lane : c_lane;
        nc_mask  = load ? mask_of(ahbls.ahbls_hsize, ahbls.ahbls_haddr) : c_mask;
        n_ce_n   = 1'b1;
        n_we_n   = 1'b1;
        n_oe_n   = 1'b1;
        n_dq_oe  = 1'b0;
        n_byte_n = '1;
        n_addr   = sram_addr;
        if (n_state == S_RBEAT || n_state == S_WSETUP || n_state == S_WSTROBE) begin
            n_ce_n   = 1'b0;
            n_addr   = nc_base + W_SRAM_ADDR'(n_beat);
            n_byte_n = ~nc_mask;
        end
        if (n_state == S_RBEAT) n_oe_n = 1'b0;
        if (n_state == S_WSETUP || n_state == S_WSTROBE) n_dq_oe = 1'b1;
        if (n_state == S_WSTROBE) n_we_n = 1'b0;

        ahbls.ahbls_hready_resp = at_boundary;
`ifdef AHB_SRAM_ERR_EN
        ahbls.ahbls_hresp = (state == S_ERR1) || (state == S_ERR2);
`else
        ahbls.ahbls_hresp = 1'b0;
`endif
        // Single-beat reads replicate the word; the final beat bypasses the capture buffer.
        ahbls.ahbls_hrdata = '0;
        if (state == S_RBEAT) begin
            for (int j = 0; j < RATIO; j++)
                ahbls.ahbls_hrdata[j * W_SRAM_DATA +: W_SRAM_DATA] =
                    (c_last == '0 || LW'(j) == cur_lane) ? sram_dq : rbuf[j];
        end
    end
endmodule

// File: tb/tb_ahb_async_sram_multibeat.sv
// tb/tb_ahb_async_sram_multibeat.sv - directed bench: WAIT=0 and WAIT=2 instances with SRAM models
`timescale 1ns/1ps
module tb_ahb_async_sram_multibeat;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic [31:0] haddr   [2];
    logic        hwrite  [2];
    logic [1:0]  htrans  [2];
    logic [2:0]  hsize   [2];
    logic [31:0] hwdata  [2];
    logic        rdy     [2];
    logic        resp    [2];
    logic [31:0] rdata_v [2];
    logic        ce_n    [2];
    logic        we_n    [2];
    logic        oe_n    [2];
    logic [1:0]  byte_n  [2];
    logic [15:0] saddr   [2];

    ahb_async_sram_multibeat_if #(.W_DATA(32), .W_ADDR(32)) bus0 ();
    ahb_async_sram_multibeat_if #(.W_DATA(32), .W_ADDR(32)) bus1 ();

    wire  [15:0] dq0, dq1;
    logic [15:0] addr0;
    logic [7:0]  addr1;
    logic [1:0]  bn0, bn1;
    logic        ce0, we0, oe0, ce1, we1, oe1;

    ahb_async_sram_multibeat #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .rst(rst[0]), .ahbls(bus0.slave), .sram_addr(addr0), .sram_dq(dq0),
        .sram_ce_n(ce0), .sram_we_n(we0), .sram_oe_n(oe0), .sram_byte_n(bn0)
    );
    ahb_async_sram_multibeat #(.WAIT_CYCLES(2), .DEPTH(256)) dut_w (
        .clk(clk), .rst(rst[1]), .ahbls(bus1.slave), .sram_addr(addr1), .sram_dq(dq1),
        .sram_ce_n(ce1), .sram_we_n(we1), .sram_oe_n(oe1), .sram_byte_n(bn1)
    );

    assign bus0.ahbls_hready = bus0.ahbls_hready_resp;
    assign bus0.ahbls_haddr = haddr[0];
    assign bus0.ahbls_hwrite = hwrite[0];
    assign bus0.ahbls_htrans = htrans[0];
    assign bus0.ahbls_hsize = hsize[0];
    assign bus0.ahbls_hwdata = hwdata[0];
    assign bus0.ahbls_hburst = 3'd0;
    assign bus0.ahbls_hprot = 4'd0;
    assign bus0.ahbls_hmastlock = 1'b0;
    assign bus1.ahbls_hready = bus1.ahbls_hready_resp;
    assign bus1.ahbls_haddr = haddr[1];
    assign bus1.ahbls_hwrite = hwrite[1];
    assign bus1.ahbls_htrans = htrans[1];
    assign bus1.ahbls_hsize = hsize[1];
    assign bus1.ahbls_hwdata = hwdata[1];
    assign bus1.ahbls_hburst = 3'd0;
    assign bus1.ahbls_hprot = 4'd0;
    assign bus1.ahbls_hmastlock = 1'b0;

    assign rdy[0] = bus0.ahbls_hready_resp;
    assign rdy[1] = bus1.ahbls_hready_resp;
    assign resp[0] = bus0.ahbls_hresp;
    assign resp[1] = bus1.ahbls_hresp;
    assign rdata_v[0] = bus0.ahbls_hrdata;
    assign rdata_v[1] = bus1.ahbls_hrdata;
    assign ce_n[0] = ce0;
    assign ce_n[1] = ce1;
    assign we_n[0] = we0;
    assign we_n[1] = we1;
    assign oe_n[0] = oe0;
    assign oe_n[1] = oe1;
    assign byte_n[0] = bn0;
    assign byte_n[1] = bn1;
    assign saddr[0] = addr0;
    assign saddr[1] = {8'h00, addr1};

    // Asynchronous SRAM models: read drives dq while selected, write latches while we_n is low.
    logic [15:0] mem0 [65536];
    logic [15:0] mem1 [256];
    assign dq0 = (!ce0 && !oe0 && we0) ? mem0[addr0] : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[addr1] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce0 && !we0) begin
            if (!bn0[0]) mem0[addr0][7:0]  = dq0[7:0];
            if (!bn0[1]) mem0[addr0][15:8] = dq0[15:8];
        end
        if (!ce1 && !we1) begin
            if (!bn1[0]) mem1[addr1][7:0]  = dq1[7:0];
            if (!bn1[1]) mem1[addr1][15:8] = dq1[15:8];
        end
    end

    int ncmp = 0;
    int nfail = 0;
    int r_cycles, r_strobe, r_ce;
    logic [31:0] r_data;
    logic r_resp_first, r_resp_last;
    logic [15:0] r_saddr;
    logic [1:0] r_bn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge where the slave is ready; returns at the negedge of the last dphase cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
        haddr[d] = a; hwrite[d] = wr; hsize[d] = sz; htrans[d] = 2'b10;
        @(negedge clk);
        htrans[d] = 2'b00; hwdata[d] = wd;
        r_cycles = 0; r_strobe = 0; r_ce = 0; r_saddr = '0; r_bn = '1;
        for (int c = 0; c < 64; c++) begin
            r_cycles++;
            if (r_cycles == 1) r_resp_first = resp[d];
            if (!ce_n[d]) r_ce++;
            if (wr ? !we_n[d] : !oe_n[d]) begin
                r_strobe++; r_saddr = saddr[d]; r_bn = byte_n[d];
            end
            if (rdy[d]) break;
            @(negedge clk);
        end
        chk("dphase_terminates", {31'd0, rdy[d]}, 32'd1);
        r_data = rdata_v[d];
        r_resp_last = resp[d];
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem0[i] = 16'h0000;
        for (int i = 0; i < 256; i++) mem1[i] = 16'h0000;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; haddr[d] = '0; hwrite[d] = 1'b0; htrans[d] = 2'b00;
            hsize[d] = 3'd0; hwdata[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_hready", {31'd0, rdy[0]}, 32'd1);
        chk("rst_hresp", {31'd0, resp[0]}, 32'd0);
        chk("rst_strobes", {29'd0, ce0, we0, oe0}, 32'd7);
        chk("rst_byte_n", {30'd0, bn0}, 32'd3);
        chk("rst_addr", {16'd0, addr0}, 32'd0);
        chk("rst_hrdata", rdata_v[0], 32'd0);
        chk("rst_dq_oe", {31'd0, dut.dq_oe}, 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        htrans[0] = 2'b01;
        @(negedge clk);
        chk("busy_hready", {31'd0, rdy[0]}, 32'd1);
        chk("busy_ce_n", {31'd0, ce0}, 32'd1);
        htrans[0] = 2'b00;

        xfer(0, 1'b1, 32'h10, 3'd2, 32'hCAFEBABE);
        chk("wr_word_cycles", r_cycles, 32'd4);
        chk("wr_word_we_low", r_strobe, 32'd2);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("mem8", {16'd0, mem0[8]}, 32'h0000BABE);
        chk("mem9", {16'd0, mem0[9]}, 32'h0000CAFE);
        chk("rd_word_cycles", r_cycles, 32'd2);
        chk("rd_word_oe_low", r_strobe, 32'd2);
        chk("rd_word_data", r_data, 32'hCAFEBABE);

        xfer(0, 1'b1, 32'h13, 3'd0, 32'hA5000000);
        chk("wr_byte_cycles", r_cycles, 32'd2);
        chk("wr_byte_addr", {16'd0, r_saddr}, 32'd9);
        chk("wr_byte_byte_n", {30'd0, r_bn}, 32'd1);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("rd_after_byte", r_data, 32'hA5FEBABE);
        xfer(0, 1'b0, 32'h12, 3'd0, 32'h0);
        chk("rd_byte_cycles", r_cycles, 32'd1);
        chk("rd_byte_byte_n", {30'd0, r_bn}, 32'd2);
        chk("rd_byte_repl", r_data, 32'hA5FEA5FE);

        xfer(1, 1'b1, 32'h6, 3'd1, 32'hBEEF0000);
        chk("w2_wr_cycles", r_cycles, 32'd4);
        chk("w2_wr_we_low", r_strobe, 32'd3);
        xfer(1, 1'b0, 32'h6, 3'd1, 32'h0);
        chk("w2_mem3", {16'd0, mem1[3]}, 32'h0000BEEF);
        chk("w2_rd_cycles", r_cycles, 32'd3);
        chk("w2_rd_oe_low", r_strobe, 32'd3);
        chk("w2_rd_data", r_data, 32'hBEEFBEEF);

        haddr[0] = 32'h20; hwrite[0] = 1'b1; hsize[0] = 3'd2; htrans[0] = 2'b10;
        @(negedge clk);
        htrans[0] = 2'b00; hwdata[0] = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_beat1_addr", {16'd0, addr0}, 32'h11);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rstmid_ce_we", {30'd0, ce0, we0}, 32'd3);
        chk("rstmid_dq_oe", {31'd0, dut.dq_oe}, 32'd0);
        chk("rstmid_hready", {31'd0, rdy[0]}, 32'd1);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rstmid_mem10", {16'd0, mem0[16'h10]}, 32'h00002222);
        chk("rstmid_mem11", {16'd0, mem0[16'h11]}, 32'h00000000);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("rstmid_read", r_data, 32'hA5FEBABE);

        xfer(0, 1'b1, 32'h0, 3'd2, 32'h12345678);
        xfer(0, 1'b0, 32'h0002_0000, 3'd2, 32'h0);
`ifdef AHB_SRAM_ERR_EN
        chk("err_cycles", r_cycles, 32'd2);
        chk("err_resp_first", {31'd0, r_resp_first}, 32'd1);
        chk("err_resp_last", {31'd0, r_resp_last}, 32'd1);
        chk("err_no_ce", r_ce, 32'd0);
        chk("err_hrdata", r_data, 32'd0);
`else
        chk("alias_cycles", r_cycles, 32'd2);
        chk("alias_resp", {31'd0, r_resp_last}, 32'd0);
        chk("alias_data", r_data, 32'h12345678);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
